// File: rtl/ooo_fetch_unit_if.sv
// Bundle of fetch-unit signals toward the pipeline and the I$.
// The master modport is the fetch unit; the slave modport is the pipeline/I$ side.
interface ooo_fetch_unit_if #(
    parameter int LOG_BTB_SETS = 8
);
    logic                    pipeline_BTB_DIRP_update;
    logic [LOG_BTB_SETS-1:0] pipeline_BTB_DIRP_index;
    logic [13:0]             pipeline_BTB_target;
    logic                    pipeline_DIRP_taken;
    logic                    pipeline_take_resolved;
    logic [13:0]             pipeline_resolved_PC;
    logic                    icache_hit;
    logic [31:0]             icache_load;
    logic                    pipeline_stall_fetch_unit;
    logic                    pipeline_halt;
    logic                    icache_REN;
    logic [31:0]             icache_addr;
    logic                    icache_halt;
    logic [31:0]             pipeline_instr;
    logic                    pipeline_ivalid;
    logic [13:0]             pipeline_PC;
    logic [13:0]             pipeline_nPC;

    modport master (
        input  pipeline_BTB_DIRP_update, pipeline_BTB_DIRP_index, pipeline_BTB_target,
               pipeline_DIRP_taken, pipeline_take_resolved, pipeline_resolved_PC,
               icache_hit, icache_load, pipeline_stall_fetch_unit, pipeline_halt,
        output icache_REN, icache_addr, icache_halt,
               pipeline_instr, pipeline_ivalid, pipeline_PC, pipeline_nPC
    );

    modport slave (
        output pipeline_BTB_DIRP_update, pipeline_BTB_DIRP_index, pipeline_BTB_target,
               pipeline_DIRP_taken, pipeline_take_resolved, pipeline_resolved_PC,
               icache_hit, icache_load, pipeline_stall_fetch_unit, pipeline_halt,
        input  icache_REN, icache_addr, icache_halt,
               pipeline_instr, pipeline_ivalid, pipeline_PC, pipeline_nPC
    );
endinterface

// File: rtl/ooo_fetch_unit.sv
// Instruction fetch: holds the fetch PC, reads the I$, and predicts the next PC
// from an untagged BTB, 2-bit direction counters and a circular return address stack.
module ooo_fetch_unit #(
    parameter logic [15:0] PC_RESET_VAL = 16'h0,
    parameter int          BTB_FRAMES   = 256,
    parameter int          RAS_DEPTH    = 8
) (
    input logic              CLK,
    input logic              nRST,
    ooo_fetch_unit_if.master bus
);
    localparam int LOG_BTB_SETS = $clog2(BTB_FRAMES);
    localparam int PTR_W        = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W        = $clog2(RAS_DEPTH + 1);

    typedef logic [13:0] pc_t;

    pc_t                     pc;
    logic                    halted;
    logic                    btb_valid  [BTB_FRAMES];
    pc_t                     btb_target [BTB_FRAMES];
    logic [1:0]              dirp       [BTB_FRAMES];
    pc_t                     ras        [RAS_DEPTH];
    logic [PTR_W-1:0]        ras_ptr;
    logic [CNT_W-1:0]        ras_cnt;

    logic [LOG_BTB_SETS-1:0] idx;
    logic [PTR_W-1:0]        ras_top;
    logic [PTR_W-1:0]        ras_next;
    logic                    is_jr31;
    logic                    is_jal;
    logic                    do_pop;
    logic                    do_push;
    logic                    accept;
    pc_t                     pc_inc;
    pc_t                     npc;

    assign bus.icache_REN  = ~halted;
    assign bus.icache_addr = {16'b0, pc, 2'b00};
    assign bus.icache_halt = halted;

    // ras_ptr names the next free slot; the top of stack sits just below it.
    always_comb begin
        idx      = pc[LOG_BTB_SETS-1:0];
        pc_inc   = pc + 14'd1;
        ras_top  = (ras_ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : ras_ptr - PTR_W'(1);
        ras_next = (ras_ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : ras_ptr + PTR_W'(1);
        is_jr31  = (bus.icache_load[31:26] == 6'b000000) && (bus.icache_load[5:0] == 6'b001000)
                   && (bus.icache_load[25:21] == 5'd31);
        is_jal   = (bus.icache_load[31:26] == 6'b000011);
        do_pop   = is_jr31 && (ras_cnt != '0);
        do_push  = is_jal;
        accept   = bus.icache_hit & ~bus.pipeline_stall_fetch_unit & ~halted
                   & ~bus.pipeline_take_resolved;
        if (do_pop)
            npc = ras[ras_top];
        else if (btb_valid[idx] && dirp[idx][1])
            npc = btb_target[idx];
        else
            npc = pc_inc;
    end

    // Training is independent of stall/halt; a same-cycle lookup sees pre-edge contents.
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            for (int i = 0; i < BTB_FRAMES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_target[i] <= '0;
                dirp[i]       <= 2'b01;
            end
        end else if (bus.pipeline_BTB_DIRP_update) begin
            btb_valid[bus.pipeline_BTB_DIRP_index]  <= 1'b1;
            btb_target[bus.pipeline_BTB_DIRP_index] <= bus.pipeline_BTB_target;
            if (bus.pipeline_DIRP_taken && dirp[bus.pipeline_BTB_DIRP_index] != 2'b11)
                dirp[bus.pipeline_BTB_DIRP_index] <= dirp[bus.pipeline_BTB_DIRP_index] + 2'b01;
            else if (!bus.pipeline_DIRP_taken && dirp[bus.pipeline_BTB_DIRP_index] != 2'b00)
                dirp[bus.pipeline_BTB_DIRP_index] <= dirp[bus.pipeline_BTB_DIRP_index] - 2'b01;
        end
    end

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            pc                  <= PC_RESET_VAL[13:0];
            halted              <= 1'b0;
            ras_ptr             <= '0;
            ras_cnt             <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
            bus.pipeline_instr  <= '0;
            bus.pipeline_ivalid <= 1'b0;
            bus.pipeline_PC     <= '0;
            bus.pipeline_nPC    <= '0;
        end else begin
            if (bus.pipeline_take_resolved) begin
                pc                  <= bus.pipeline_resolved_PC;
                bus.pipeline_ivalid <= 1'b0;
            end else if (!bus.pipeline_stall_fetch_unit) begin
                if (accept) begin
                    pc                  <= npc;
                    bus.pipeline_instr  <= bus.icache_load;
                    bus.pipeline_ivalid <= 1'b1;
                    bus.pipeline_PC     <= pc;
                    bus.pipeline_nPC    <= npc;
                    // A full stack keeps its count; the circular write drops the oldest entry.
                    if (do_push) begin
                        ras[ras_ptr] <= pc_inc;
                        ras_ptr      <= ras_next;
                        if (ras_cnt != CNT_W'(RAS_DEPTH)) ras_cnt <= ras_cnt + CNT_W'(1);
                    end else if (do_pop) begin
                        ras_ptr <= ras_top;
                        ras_cnt <= ras_cnt - CNT_W'(1);
                    end
                end else begin
                    bus.pipeline_ivalid <= 1'b0;
                end
            end
            if (bus.pipeline_halt) begin
                halted              <= 1'b1;
                bus.pipeline_ivalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ooo_fetch_unit.sv
// Directed bench for ooo_fetch_unit: reset, sequential fetch, BTB/DIRP training,
// JAL/JR return prediction, redirect, stall and sticky halt.
module tb_ooo_fetch_unit;
    logic CLK;
    logic nRST;
    int   checks;
    int   errors;

    localparam logic [31:0] ADDI = 32'h20010005;
    localparam logic [31:0] JAL  = 32'h0C000000;
    localparam logic [31:0] JR31 = 32'h03E00008;

    ooo_fetch_unit_if #(.LOG_BTB_SETS(8)) bus ();

    ooo_fetch_unit #(.PC_RESET_VAL(16'h0), .BTB_FRAMES(256), .RAS_DEPTH(8)) dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.pipeline_BTB_DIRP_update  = 1'b0;
        bus.pipeline_BTB_DIRP_index   = '0;
        bus.pipeline_BTB_target       = '0;
        bus.pipeline_DIRP_taken       = 1'b0;
        bus.pipeline_take_resolved    = 1'b0;
        bus.pipeline_resolved_PC      = '0;
        bus.icache_hit                = 1'b0;
        bus.icache_load               = '0;
        bus.pipeline_stall_fetch_unit = 1'b0;
        bus.pipeline_halt             = 1'b0;
    endtask

    task automatic redirect(input logic [13:0] target);
        bus.pipeline_take_resolved = 1'b1;
        bus.pipeline_resolved_PC   = target;
        step();
        bus.pipeline_take_resolved = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        nRST = 1'b1;
        repeat (2) step();
        checks++; if (bus.pipeline_ivalid !== 1'b0) begin errors++; $display("FAIL rst_ivalid_in_reset got %b exp 0", bus.pipeline_ivalid); end
        nRST = 1'b0;
        step();
        checks++; if (bus.icache_REN !== 1'b1) begin errors++; $display("FAIL rst_ren got %b exp 1", bus.icache_REN); end
        checks++; if (bus.icache_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", bus.icache_addr); end
        checks++; if (bus.icache_halt !== 1'b0) begin errors++; $display("FAIL rst_halt got %b exp 0", bus.icache_halt); end
        checks++; if (bus.pipeline_ivalid !== 1'b0) begin errors++; $display("FAIL rst_ivalid got %b exp 0", bus.pipeline_ivalid); end
        checks++; if (bus.pipeline_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", bus.pipeline_instr); end
        checks++; if (bus.pipeline_PC !== 14'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", bus.pipeline_PC); end
        checks++; if (bus.pipeline_nPC !== 14'h0) begin errors++; $display("FAIL rst_npc got %h exp 0", bus.pipeline_nPC); end
    endtask

    task automatic test_sequential();
        bus.icache_hit  = 1'b1;
        bus.icache_load = ADDI;
        step();
        checks++; if (bus.pipeline_ivalid !== 1'b1) begin errors++; $display("FAIL seq_ivalid0 got %b exp 1", bus.pipeline_ivalid); end
        checks++; if (bus.pipeline_instr !== ADDI) begin errors++; $display("FAIL seq_instr0 got %h exp %h", bus.pipeline_instr, ADDI); end
        checks++; if (bus.pipeline_PC !== 14'h0) begin errors++; $display("FAIL seq_pc0 got %h exp 0", bus.pipeline_PC); end
        checks++; if (bus.pipeline_nPC !== 14'h1) begin errors++; $display("FAIL seq_npc0 got %h exp 1", bus.pipeline_nPC); end
        checks++; if (bus.icache_addr !== 32'h4) begin errors++; $display("FAIL seq_addr0 got %h exp 4", bus.icache_addr); end
        step();
        checks++; if (bus.pipeline_PC !== 14'h1) begin errors++; $display("FAIL seq_pc1 got %h exp 1", bus.pipeline_PC); end
        checks++; if (bus.pipeline_nPC !== 14'h2) begin errors++; $display("FAIL seq_npc1 got %h exp 2", bus.pipeline_nPC); end
        checks++; if (bus.icache_addr !== 32'h8) begin errors++; $display("FAIL seq_addr1 got %h exp 8", bus.icache_addr); end
        bus.icache_hit = 1'b0;
        step();
        checks++; if (bus.pipeline_ivalid !== 1'b0) begin errors++; $display("FAIL miss_ivalid got %b exp 0", bus.pipeline_ivalid); end
        checks++; if (bus.icache_addr !== 32'h8) begin errors++; $display("FAIL miss_addr_hold got %h exp 8", bus.icache_addr); end
        checks++; if (bus.pipeline_PC !== 14'h1) begin errors++; $display("FAIL miss_pc_hold got %h exp 1", bus.pipeline_PC); end
    endtask

    task automatic test_btb_training();
        bus.pipeline_BTB_DIRP_update = 1'b1;
        bus.pipeline_BTB_DIRP_index  = 8'd4;
        bus.pipeline_BTB_target      = 14'h40;
        bus.pipeline_DIRP_taken      = 1'b1;
        repeat (2) step();
        bus.pipeline_BTB_DIRP_update = 1'b0;
        redirect(14'h4);
        checks++; if (bus.pipeline_ivalid !== 1'b0) begin errors++; $display("FAIL redir4_ivalid got %b exp 0", bus.pipeline_ivalid); end
        checks++; if (bus.icache_addr !== 32'h10) begin errors++; $display("FAIL redir4_addr got %h exp 10", bus.icache_addr); end
        bus.icache_hit  = 1'b1;
        bus.icache_load = ADDI;
        step();
        bus.icache_hit = 1'b0;
        checks++; if (bus.pipeline_PC !== 14'h4) begin errors++; $display("FAIL btb_pc got %h exp 4", bus.pipeline_PC); end
        checks++; if (bus.pipeline_nPC !== 14'h40) begin errors++; $display("FAIL btb_npc got %h exp 40", bus.pipeline_nPC); end
        checks++; if (bus.icache_addr !== 32'h100) begin errors++; $display("FAIL btb_addr got %h exp 100", bus.icache_addr); end
        // Two not-taken updates walk the counter 11 -> 10 -> 01: predict fall-through.
        bus.pipeline_BTB_DIRP_update = 1'b1;
        bus.pipeline_DIRP_taken      = 1'b0;
        repeat (2) step();
        bus.pipeline_BTB_DIRP_update = 1'b0;
        redirect(14'h4);
        bus.icache_hit = 1'b1;
        step();
        bus.icache_hit = 1'b0;
        checks++; if (bus.pipeline_nPC !== 14'h5) begin errors++; $display("FAIL btb_nt_npc got %h exp 5", bus.pipeline_nPC); end
        checks++; if (bus.icache_addr !== 32'h14) begin errors++; $display("FAIL btb_nt_addr got %h exp 14", bus.icache_addr); end
    endtask

    task automatic test_ras();
        redirect(14'h8);
        bus.icache_hit  = 1'b1;
        bus.icache_load = JAL;
        step();
        checks++; if (bus.pipeline_PC !== 14'h8) begin errors++; $display("FAIL jal_pc got %h exp 8", bus.pipeline_PC); end
        checks++; if (bus.pipeline_nPC !== 14'h9) begin errors++; $display("FAIL jal_npc got %h exp 9", bus.pipeline_nPC); end
        bus.icache_load = JR31;
        step();
        checks++; if (bus.pipeline_PC !== 14'h9) begin errors++; $display("FAIL jr_pc got %h exp 9", bus.pipeline_PC); end
        checks++; if (bus.pipeline_nPC !== 14'h9) begin errors++; $display("FAIL jr_npc got %h exp 9", bus.pipeline_nPC); end
        checks++; if (bus.icache_addr !== 32'h24) begin errors++; $display("FAIL jr_addr got %h exp 24", bus.icache_addr); end
        // Redirect together with a hit: the hit is dropped.
        redirect(14'h20);
        checks++; if (bus.pipeline_ivalid !== 1'b0) begin errors++; $display("FAIL redir_hit_ivalid got %b exp 0", bus.pipeline_ivalid); end
        checks++; if (bus.icache_addr !== 32'h80) begin errors++; $display("FAIL redir_hit_addr got %h exp 80", bus.icache_addr); end
        checks++; if (bus.pipeline_PC !== 14'h9) begin errors++; $display("FAIL redir_hit_pc_hold got %h exp 9", bus.pipeline_PC); end
        // RAS is now empty, so JR $31 falls back to PC+1.
        step();
        checks++; if (bus.pipeline_nPC !== 14'h21) begin errors++; $display("FAIL jr_empty_npc got %h exp 21", bus.pipeline_nPC); end
        checks++; if (bus.icache_addr !== 32'h84) begin errors++; $display("FAIL jr_empty_addr got %h exp 84", bus.icache_addr); end
    endtask

    task automatic test_stall();
        bus.pipeline_stall_fetch_unit = 1'b1;
        bus.icache_load               = ADDI;
        repeat (2) step();
        checks++; if (bus.pipeline_ivalid !== 1'b1) begin errors++; $display("FAIL stall_ivalid got %b exp 1", bus.pipeline_ivalid); end
        checks++; if (bus.pipeline_instr !== JR31) begin errors++; $display("FAIL stall_instr got %h exp %h", bus.pipeline_instr, JR31); end
        checks++; if (bus.pipeline_PC !== 14'h20) begin errors++; $display("FAIL stall_pc got %h exp 20", bus.pipeline_PC); end
        checks++; if (bus.icache_addr !== 32'h84) begin errors++; $display("FAIL stall_addr got %h exp 84", bus.icache_addr); end
        bus.pipeline_stall_fetch_unit = 1'b0;
        step();
        bus.icache_hit = 1'b0;
        checks++; if (bus.pipeline_PC !== 14'h21) begin errors++; $display("FAIL unstall_pc got %h exp 21", bus.pipeline_PC); end
        checks++; if (bus.pipeline_nPC !== 14'h22) begin errors++; $display("FAIL unstall_npc got %h exp 22", bus.pipeline_nPC); end
        checks++; if (bus.icache_addr !== 32'h88) begin errors++; $display("FAIL unstall_addr got %h exp 88", bus.icache_addr); end
    endtask

    task automatic test_halt();
        bus.pipeline_halt = 1'b1;
        step();
        bus.pipeline_halt = 1'b0;
        checks++; if (bus.icache_REN !== 1'b0) begin errors++; $display("FAIL halt_ren got %b exp 0", bus.icache_REN); end
        checks++; if (bus.icache_halt !== 1'b1) begin errors++; $display("FAIL halt_flag got %b exp 1", bus.icache_halt); end
        checks++; if (bus.pipeline_ivalid !== 1'b0) begin errors++; $display("FAIL halt_ivalid got %b exp 0", bus.pipeline_ivalid); end
        bus.icache_hit = 1'b1;
        repeat (3) step();
        checks++; if (bus.icache_halt !== 1'b1) begin errors++; $display("FAIL halt_sticky got %b exp 1", bus.icache_halt); end
        checks++; if (bus.pipeline_ivalid !== 1'b0) begin errors++; $display("FAIL halt_sticky_ivalid got %b exp 0", bus.pipeline_ivalid); end
        checks++; if (bus.icache_addr !== 32'h88) begin errors++; $display("FAIL halt_addr_hold got %h exp 88", bus.icache_addr); end
        bus.icache_hit = 1'b0;
        nRST = 1'b1;
        step();
        nRST = 1'b0;
        step();
        checks++; if (bus.icache_REN !== 1'b1) begin errors++; $display("FAIL halt_clear_ren got %b exp 1", bus.icache_REN); end
        checks++; if (bus.icache_halt !== 1'b0) begin errors++; $display("FAIL halt_clear_flag got %b exp 0", bus.icache_halt); end
        checks++; if (bus.icache_addr !== 32'h0) begin errors++; $display("FAIL halt_clear_addr got %h exp 0", bus.icache_addr); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sequential();
        test_btb_training();
        test_ras();
        test_stall();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
